// File: rtl/vta_host_responder.sv
// Host request target: decodes read/write requests into the accelerator
// control/status register file and answers with a deq pulse plus read data.
module vta_host_responder #(
   parameter int unsigned ADDR_BITS    = 8,
   parameter int unsigned DATA_BITS    = 32,
   parameter int unsigned NUM_REGS     = 8,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             dpi_req_valid,
   input  logic                             dpi_req_opcode,
   input  logic [ADDR_BITS-1:0]             dpi_req_addr,
   input  logic [DATA_BITS-1:0]             dpi_req_value,
   output logic                             dpi_req_deq,
   output logic                             dpi_resp_valid,
   output logic [DATA_BITS-1:0]             dpi_resp_bits,
   output logic                             launch,
   input  logic                             finish,
   output logic [(NUM_REGS-2)*DATA_BITS-1:0] args
);

   localparam int unsigned IDX_W = ADDR_BITS - 2;
   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int unsigned NARGS = NUM_REGS - 2;

   typedef enum logic {
      ST_IDLE,
      ST_DRAIN
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 deq_q, deq_d;
   logic                 resp_valid_q, resp_valid_d;
   logic [DATA_BITS-1:0] resp_bits_q, resp_bits_d;
   logic [1:0]           ctrl_q, ctrl_d;
   logic [DATA_BITS-1:0] cycles_q, cycles_d;
   logic [DATA_BITS-1:0] args_q [NARGS];
   logic [DATA_BITS-1:0] args_d [NARGS];

   logic [IDX_W-1:0]     req_idx;
   logic [DATA_BITS-1:0] rd_data;
   logic                 accept;
   logic                 unused_addr_bits;

   assign req_idx          = dpi_req_addr[ADDR_BITS-1:2];
   assign unused_addr_bits = ^dpi_req_addr[1:0];
   assign accept           = (state_q == ST_IDLE) && dpi_req_valid;

   // Indices at or beyond NUM_REGS fall through to zero.
   always_comb begin
      rd_data = '0;
      if (req_idx == IDX_W'(0)) begin
         rd_data = {{(DATA_BITS-2){1'b0}}, ctrl_q};
      end else if (req_idx == IDX_W'(1)) begin
         rd_data = cycles_q;
      end else begin
         for (int unsigned i = 0; i < NARGS; i++) begin
            if (req_idx == IDX_W'(i + 2)) begin
               rd_data = args_q[i];
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      deq_d        = 1'b0;
      resp_valid_d = 1'b0;
      resp_bits_d  = resp_bits_q;
      ctrl_d       = ctrl_q;
      cycles_d     = cycles_q;
      args_d       = args_q;

      if (ctrl_q[0]) begin
         cycles_d = cycles_q + DATA_BITS'(1);
      end

      if (state_q == ST_IDLE) begin
         if (accept) begin
            deq_d   = 1'b1;
            state_d = ST_DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
            if (dpi_req_opcode) begin
               if (req_idx == IDX_W'(0)) begin
                  ctrl_d = dpi_req_value[1:0];
                  // Launch clear beats the running increment.
                  if (dpi_req_value[0]) begin
                     cycles_d = '0;
                  end
               end
               for (int unsigned i = 0; i < NARGS; i++) begin
                  if (req_idx == IDX_W'(i + 2)) begin
                     args_d[i] = dpi_req_value;
                  end
               end
            end else begin
               resp_valid_d = 1'b1;
               resp_bits_d  = rd_data;
            end
         end
      end else begin
         if (cnt_q == '0) begin
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      // Core completion overrides any same-cycle ctrl write.
      if (finish) begin
         ctrl_d = 2'b10;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         deq_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_bits_q  <= '0;
         ctrl_q       <= '0;
         cycles_q     <= '0;
         args_q       <= '{default: '0};
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         deq_q        <= deq_d;
         resp_valid_q <= resp_valid_d;
         resp_bits_q  <= resp_bits_d;
         ctrl_q       <= ctrl_d;
         cycles_q     <= cycles_d;
         args_q       <= args_d;
      end
   end

   assign dpi_req_deq    = deq_q;
   assign dpi_resp_valid = resp_valid_q;
   assign dpi_resp_bits  = resp_bits_q;
   assign launch         = ctrl_q[0];

   for (genvar g = 0; g < NARGS; g++) begin : g_args
      assign args[g*DATA_BITS +: DATA_BITS] = args_q[g];
   end

endmodule

// File: tb/tb_vta_host_responder.sv
// Directed bench for vta_host_responder: vector table plus hand-written
// sequences for launch/finish timing and reset during drain.
module tb_vta_host_responder;

   logic         clock;
   logic         reset;
   logic         dpi_req_valid;
   logic         dpi_req_opcode;
   logic [7:0]   dpi_req_addr;
   logic [31:0]  dpi_req_value;
   logic         dpi_req_deq;
   logic         dpi_resp_valid;
   logic [31:0]  dpi_resp_bits;
   logic         launch;
   logic         finish;
   logic [191:0] args;

   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] exp_bits;

   vta_host_responder #(
      .ADDR_BITS(8),
      .DATA_BITS(32),
      .NUM_REGS(8),
      .DRAIN_CYCLES(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .dpi_req_valid(dpi_req_valid),
      .dpi_req_opcode(dpi_req_opcode),
      .dpi_req_addr(dpi_req_addr),
      .dpi_req_value(dpi_req_value),
      .dpi_req_deq(dpi_req_deq),
      .dpi_resp_valid(dpi_resp_valid),
      .dpi_resp_bits(dpi_resp_bits),
      .launch(launch),
      .finish(finish),
      .args(args)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] val;
      logic [31:0] exp_rd;
      int unsigned ai;
      logic [31:0] exp_arg;
   } vec_t;

   vec_t tbl [12];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Valid is held through the drain window to show it is ignored there.
   task automatic do_req(input string tag, input bit wr, input logic [7:0] a,
                         input logic [31:0] v, input logic [31:0] exp_rd);
      dpi_req_valid  = 1'b1;
      dpi_req_opcode = wr;
      dpi_req_addr   = a;
      dpi_req_value  = v;
      tick();
      check({tag, "_deq_t1"}, dpi_req_deq, 1'b1);
      check({tag, "_rv_t1"}, dpi_resp_valid, !wr);
      if (!wr) begin
         exp_bits = exp_rd;
         check({tag, "_rdata"}, dpi_resp_bits, exp_rd);
      end
      tick();
      check({tag, "_deq_t2"}, dpi_req_deq, 1'b0);
      check({tag, "_rv_t2"}, dpi_resp_valid, 1'b0);
      tick();
      check({tag, "_deq_t3"}, dpi_req_deq, 1'b0);
      check({tag, "_hold"}, dpi_resp_bits, exp_bits);
      dpi_req_valid = 1'b0;
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      exp_bits       = '0;
      reset          = 1'b1;
      dpi_req_valid  = 1'b0;
      dpi_req_opcode = 1'b0;
      dpi_req_addr   = '0;
      dpi_req_value  = '0;
      finish         = 1'b0;

      tbl[0]  = '{1'b1, 8'h08, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 8'h08, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 8'h0B, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF};
      tbl[3]  = '{1'b1, 8'h14, 32'h12345678, 32'h0,        3, 32'h12345678};
      tbl[4]  = '{1'b0, 8'h14, 32'h0,        32'h12345678, 3, 32'h12345678};
      tbl[5]  = '{1'b1, 8'h1C, 32'hA5A55A5A, 32'h0,        5, 32'hA5A55A5A};
      tbl[6]  = '{1'b0, 8'h1C, 32'h0,        32'hA5A55A5A, 5, 32'hA5A55A5A};
      tbl[7]  = '{1'b0, 8'h40, 32'h0,        32'h0,        0, 32'hDEADBEEF};
      tbl[8]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 32'h0,        0, 32'hDEADBEEF};
      tbl[9]  = '{1'b1, 8'h04, 32'h00000055, 32'h0,        1, 32'h0};
      tbl[10] = '{1'b0, 8'h04, 32'h0,        32'h0,        1, 32'h0};
      tbl[11] = '{1'b0, 8'h20, 32'h0,        32'h0,        5, 32'hA5A55A5A};

      tick();
      tick();
      reset = 1'b0;
      check("rst_deq", dpi_req_deq, 1'b0);
      check("rst_rv", dpi_resp_valid, 1'b0);
      check("rst_bits", dpi_resp_bits, 32'h0);
      check("rst_launch", launch, 1'b0);
      check("rst_args", args, 192'h0);
      tick();

      for (int i = 0; i < 12; i++) begin
         do_req($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].val, tbl[i].exp_rd);
         check($sformatf("vec%0d_arg", i), args[tbl[i].ai*32 +: 32], tbl[i].exp_arg);
         check($sformatf("vec%0d_launch", i), launch, 1'b0);
      end
      check("tbl_args_all", args,
            {32'hA5A55A5A, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'hDEADBEEF});

      // Launch for 10 cycles: t+1..t+10, finish sampled at the end of t+10.
      do_req("launch_wr", 1'b1, 8'h00, 32'h1, 32'h0);
      check("launch_on", launch, 1'b1);
      for (int i = 0; i < 7; i++) tick();
      check("launch_still_on", launch, 1'b1);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      check("launch_off", launch, 1'b0);
      do_req("rd_ctrl", 1'b0, 8'h00, 32'h0, 32'h2);
      do_req("rd_cycles", 1'b0, 8'h04, 32'h0, 32'd10);
      do_req("rd_oob_ctrl", 1'b0, 8'h40, 32'h0, 32'h0);

      // finish and a launch write on the same edge.
      dpi_req_valid  = 1'b1;
      dpi_req_opcode = 1'b1;
      dpi_req_addr   = 8'h00;
      dpi_req_value  = 32'h1;
      finish         = 1'b1;
      tick();
      finish = 1'b0;
      check("race_deq", dpi_req_deq, 1'b1);
      check("race_launch", launch, 1'b0);
      tick();
      tick();
      dpi_req_valid = 1'b0;
      do_req("race_rd_ctrl", 1'b0, 8'h00, 32'h0, 32'h2);
      do_req("race_rd_cycles", 1'b0, 8'h04, 32'h0, 32'h0);

      // Reset asserted during the drain of a read.
      dpi_req_valid  = 1'b1;
      dpi_req_opcode = 1'b0;
      dpi_req_addr   = 8'h08;
      tick();
      check("dr_deq", dpi_req_deq, 1'b1);
      check("dr_rv", dpi_resp_valid, 1'b1);
      check("dr_bits", dpi_resp_bits, 32'hDEADBEEF);
      #1 reset = 1'b1;
      #1;
      check("dr_rst_deq", dpi_req_deq, 1'b0);
      check("dr_rst_rv", dpi_resp_valid, 1'b0);
      check("dr_rst_bits", dpi_resp_bits, 32'h0);
      check("dr_rst_args", args, 192'h0);
      dpi_req_valid = 1'b0;
      tick();
      tick();
      reset    = 1'b0;
      exp_bits = '0;
      tick();
      do_req("post_wr", 1'b1, 8'h08, 32'h11, 32'h0);
      check("post_arg0", args[31:0], 32'h11);
      do_req("post_rd", 1'b0, 8'h08, 32'h0, 32'h11);
      do_req("post_ctrl", 1'b0, 8'h00, 32'h0, 32'h0);
      do_req("post_arg5", 1'b0, 8'h1C, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
